// File: rtl/async_fifo_rx_out_stage_if.sv
// Bundle between the read-side output stage, the read pointer handler and the consumer.
// The master modport is the output stage itself.
interface async_fifo_rx_out_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  fifo_pop;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;
  logic [1:0]            occupancy;
  logic [CNT_WIDTH-1:0]  words_delivered;

  modport master (
    input  fifo_empty, fifo_rdata, out_ready,
    output fifo_pop, out_valid, out_data, occupancy, words_delivered
  );

  modport slave (
    output fifo_empty, fifo_rdata, out_ready,
    input  fifo_pop, out_valid, out_data, occupancy, words_delivered
  );

endinterface

// File: rtl/async_fifo_rx_out_stage.sv
// Read-side output stage of the async FIFO: pops words into a 2-entry skid buffer
// (head, then skid) and presents them on a registered valid/ready port.
module async_fifo_rx_out_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk_rx,
  input  logic                          nrst_rx,
  async_fifo_rx_out_stage_if.master     bus
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [1:0]            occ_q;
  logic                  valid_q;
  logic [CNT_WIDTH-1:0]  delivered_q;
  logic                  pop;
  logic                  hs;

  // Pop depends only on local occupancy, so consumer ready never reaches the pointer logic.
  assign pop = nrst_rx & ~bus.fifo_empty & (occ_q != 2'd2);
  assign hs  = valid_q & bus.out_ready;

  always_ff @(posedge clk_rx) begin
    if (!nrst_rx) begin
      head_q      <= '0;
      skid_q      <= '0;
      occ_q       <= 2'd0;
      valid_q     <= 1'b0;
      delivered_q <= '0;
    end else begin
      if (hs) begin
        delivered_q <= delivered_q + CNT_WIDTH'(1);
      end
      case (occ_q)
        2'd0: begin
          if (pop) begin
            head_q  <= bus.fifo_rdata;
            occ_q   <= 2'd1;
            valid_q <= 1'b1;
          end
        end
        2'd1: begin
          if (pop && hs) begin
            head_q <= bus.fifo_rdata;
          end else if (pop) begin
            skid_q <= bus.fifo_rdata;
            occ_q  <= 2'd2;
          end else if (hs) begin
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
          end
        end
        2'd2: begin
          if (hs) begin
            head_q <= skid_q;
            occ_q  <= 2'd1;
          end
        end
        default: begin
          occ_q   <= 2'd0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_pop        = pop;
  assign bus.out_valid       = valid_q;
  assign bus.out_data        = head_q;
  assign bus.occupancy       = occ_q;
  assign bus.words_delivered = delivered_q;

endmodule

// File: tb/tb_async_fifo_rx_out_stage.sv
// Bench for async_fifo_rx_out_stage: an unbounded FIFO stand-in feeds the stage and a
// queue model of the stage contents is compared against the outputs every cycle.
module tb_async_fifo_rx_out_stage;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 4;

  logic clk_rx = 1'b0;
  logic nrst_rx;

  async_fifo_rx_out_stage_if #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  async_fifo_rx_out_stage #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_rx  (clk_rx),
    .nrst_rx (nrst_rx),
    .bus     (bus)
  );

  always #5 clk_rx = ~clk_rx;

  logic [DATA_WIDTH-1:0] mem [0:255];
  logic [7:0]            wr = 8'd0;
  logic [7:0]            rd = 8'd0;
  logic                  stuck_nonempty;
  int                    pop_count = 0;
  logic [DATA_WIDTH-1:0] exp_q [$];
  int                    exp_cnt = 0;
  logic                  cmp_en = 1'b0;
  int                    checks = 0;
  int                    errors = 0;

  assign bus.fifo_empty = (rd == wr) & ~stuck_nonempty;
  assign bus.fifo_rdata = mem[rd];

  // FIFO stand-in follows the DUT's pop; the model follows the stage's stated pop/handshake rules.
  always @(posedge clk_rx) begin
    if (bus.fifo_pop) pop_count <= pop_count + 1;
    if (!nrst_rx) begin
      rd <= wr;
      exp_q.delete();
      exp_cnt = 0;
    end else begin
      logic model_pop;
      logic [DATA_WIDTH-1:0] word;
      model_pop = !bus.fifo_empty && (exp_q.size() < 2);
      word      = bus.fifo_rdata;
      if (bus.fifo_pop) rd <= rd + 8'd1;
      if (exp_q.size() != 0 && bus.out_ready) begin
        exp_q.delete(0);
        exp_cnt = (exp_cnt + 1) % (1 << CNT_WIDTH);
      end
      if (model_pop) exp_q.push_back(word);
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk_rx);
      if (cmp_en) begin
        logic exp_pop;
        exp_pop = nrst_rx && !bus.fifo_empty && (exp_q.size() < 2);
        check_output("fifo_pop", 64'(bus.fifo_pop), 64'(exp_pop));
        check_output("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
        check_output("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
        check_output("words_delivered", 64'(bus.words_delivered), 64'(exp_cnt));
        if (exp_q.size() != 0) check_output("out_data", 64'(bus.out_data), 64'(exp_q[0]));
      end
    end
  endtask

  task automatic step();
    @(posedge clk_rx);
    #2;
  endtask

  task automatic apply_stimulus(input logic [DATA_WIDTH-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr] = first + DATA_WIDTH'(i);
      wr      = wr + 8'd1;
    end
  endtask

  task automatic do_reset();
    nrst_rx = 1'b0;
    step();
    nrst_rx = 1'b1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    nrst_rx        = 1'b0;
    stuck_nonempty = 1'b1;
    bus.out_ready  = 1'b0;
    fork compare_loop(); join_none

    // reset held for three edges while the FIFO claims to be non-empty
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_rx);
      cmp_en = 1'b1;
      @(negedge clk_rx);
      check_output("rst_pop", 64'(bus.fifo_pop), 64'd0);
    end
    check_output("rst_valid", 64'(bus.out_valid), 64'd0);
    check_output("rst_data", 64'(bus.out_data), 64'd0);
    check_output("rst_occ", 64'(bus.occupancy), 64'd0);
    check_output("rst_count", 64'(bus.words_delivered), 64'd0);
    stuck_nonempty = 1'b0;
    nrst_rx        = 1'b1;

    // single word
    bus.out_ready = 1'b1;
    base = pop_count;
    step();
    apply_stimulus(32'hA5A5_0001, 1);
    @(negedge clk_rx);
    check_output("single_pop_hi", 64'(bus.fifo_pop), 64'd1);
    @(negedge clk_rx);
    check_output("single_pop_lo", 64'(bus.fifo_pop), 64'd0);
    check_output("single_valid", 64'(bus.out_valid), 64'd1);
    check_output("single_data", 64'(bus.out_data), 64'hA5A5_0001);
    @(negedge clk_rx);
    check_output("single_occ", 64'(bus.occupancy), 64'd0);
    check_output("single_count", 64'(bus.words_delivered), 64'd1);
    check_output("single_pops", 64'(pop_count - base), 64'd1);

    // streaming 1..8 with ready held high
    do_reset();
    apply_stimulus(32'd1, 8);
    @(negedge clk_rx);
    check_output("stream_first_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_rx);
      check_output("stream_valid", 64'(bus.out_valid), 64'd1);
      check_output("stream_data", 64'(bus.out_data), 64'(i));
    end
    @(negedge clk_rx);
    check_output("stream_end_valid", 64'(bus.out_valid), 64'd0);
    check_output("stream_count", 64'(bus.words_delivered), 64'd8);

    // backpressure: only two pops, then drain without a bubble
    bus.out_ready = 1'b0;
    do_reset();
    base = pop_count;
    apply_stimulus(32'd1, 8);
    repeat (10) @(negedge clk_rx);
    check_output("bp_pops", 64'(pop_count - base), 64'd2);
    check_output("bp_occ", 64'(bus.occupancy), 64'd2);
    check_output("bp_pop_lo", 64'(bus.fifo_pop), 64'd0);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      if (i > 1) @(negedge clk_rx);
      check_output("bp_valid", 64'(bus.out_valid), 64'd1);
      check_output("bp_data", 64'(bus.out_data), 64'(i));
    end
    @(negedge clk_rx);
    check_output("bp_end_valid", 64'(bus.out_valid), 64'd0);

    // reset while the stage is full discards both words
    bus.out_ready = 1'b0;
    do_reset();
    apply_stimulus(32'h100, 8);
    repeat (3) step();
    check_output("mid_occ_full", 64'(bus.occupancy), 64'd2);
    nrst_rx = 1'b0;
    @(negedge clk_rx);
    check_output("mid_rst_pop", 64'(bus.fifo_pop), 64'd0);
    step();
    nrst_rx = 1'b1;
    @(negedge clk_rx);
    check_output("mid_valid", 64'(bus.out_valid), 64'd0);
    check_output("mid_data", 64'(bus.out_data), 64'd0);
    check_output("mid_occ", 64'(bus.occupancy), 64'd0);
    check_output("mid_count", 64'(bus.words_delivered), 64'd0);
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk_rx);
      check_output("mid_no_stale", 64'(bus.out_valid), 64'd0);
    end
    apply_stimulus(32'h77, 1);
    repeat (3) @(negedge clk_rx);
    check_output("mid_fresh_count", 64'(bus.words_delivered), 64'd1);

    // counter wrap at 2^CNT_WIDTH
    do_reset();
    apply_stimulus(32'h200, 17);
    repeat (25) @(negedge clk_rx);
    check_output("wrap_count", 64'(bus.words_delivered), 64'd1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
